sram_table_loader: RTL and testbench

- Write-side companion to the sine/cosine phase-lookup counter; fills both 32x512 dual-port SRAM tables through their shared port 0.
- Accepts a valid/ready stream of {sine, cosine} word pairs. Writes each pair to consecutive addresses from a programmable base, with wrap-around.
- Drives csb0/web0/wmask0/addr0/din00/din01 directly. Raises rd_inhibit so the lookup side can hold csb1 high while a load is in progress.

---
 rtl/sram_table_loader.sv | 160 ++++++++++++++++
 tb/tb_sram_table_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_table_loader
// Purpose  : Streams {sine, cosine} word pairs into the two lookup SRAMs
//            through their shared write port 0, with wrap-around addressing.
// Revision : 1.0 - initial release
// ============================================================================
module sram_table_loader #(
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 32,
  parameter logic [3:0]  WMASK = 4'hF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sine,
  input  logic [DW-1:0] in_cosine,
  output logic          csb0,
  output logic          web0,
  output logic [3:0]    wmask0,
  output logic [AW-1:0] addr0,
  output logic [DW-1:0] din00,
  output logic [DW-1:0] din01,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          rd_inhibit,
  output logic [DW-1:0] checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_remaining;
  logic          r_csb;
  logic          r_web;
  logic [3:0]    r_wmask;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din_sine;
  logic [DW-1:0] r_din_cosine;
  logic          r_done;
  logic          r_aborted;
  logic [DW-1:0] r_checksum;

  logic          w_loading;
  logic          w_accept;
  logic          w_last;
  logic          w_start_load;
  logic          w_start_empty;

  assign w_loading     = (r_state == S_LOAD);
  assign w_accept      = w_loading && in_valid;
  assign w_last        = w_accept && (r_remaining == {{AW{1'b0}}, 1'b1});
  assign w_start_load  = (r_state == S_IDLE) && start && (count != '0);
  assign w_start_empty = (r_state == S_IDLE) && start && (count == '0);

  // Control: state, write pointer and words-left counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_load) begin
            r_ptr       <= base_addr;
            r_remaining <= count;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
          // An abort still lets a word accepted on the same edge be written.
          if (w_last || abort) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM port-0 pins are registered so a write is stable for a full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csb        <= 1'b1;
      r_web        <= 1'b1;
      r_wmask      <= 4'h0;
      r_addr       <= '0;
      r_din_sine   <= '0;
      r_din_cosine <= '0;
    end else if (w_accept) begin
      r_csb        <= 1'b0;
      r_web        <= 1'b0;
      r_wmask      <= WMASK;
      r_addr       <= r_ptr;
      r_din_sine   <= in_sine;
      r_din_cosine <= in_cosine;
    end else begin
      r_csb        <= 1'b1;
      r_web        <= 1'b1;
      r_wmask      <= 4'h0;
    end
  end

  // Status: done pulse, sticky abort flag and running checksum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_done <= w_start_empty || (r_state == S_FLUSH);

      if (w_start_load || w_start_empty) begin
        r_aborted <= 1'b0;
      end else if (w_loading && abort) begin
        r_aborted <= 1'b1;
      end

      if (w_start_load) begin
        r_checksum <= '0;
      end else if (w_accept) begin
        r_checksum <= r_checksum + (in_sine ^ in_cosine);
      end
    end
  end

  assign in_ready   = w_loading;
  assign busy       = (r_state != S_IDLE);
  assign rd_inhibit = busy || r_done;
  assign csb0       = r_csb;
  assign web0       = r_web;
  assign wmask0     = r_wmask;
  assign addr0      = r_addr;
  assign din00      = r_din_sine;
  assign din01      = r_din_cosine;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_sram_table_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_table_loader
// Purpose  : Directed self-checking bench for sram_table_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_table_loader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sine;
  logic [DW-1:0] in_cosine;
  logic          csb0;
  logic          web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din00;
  logic [DW-1:0] din01;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          rd_inhibit;
  logic [DW-1:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  sram_table_loader #(.AW(AW), .DW(DW), .WMASK(4'hF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .count      (count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sine    (in_sine),
    .in_cosine  (in_cosine),
    .csb0       (csb0),
    .web0       (web0),
    .wmask0     (wmask0),
    .addr0      (addr0),
    .din00      (din00),
    .din01      (din01),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .rd_inhibit (rd_inhibit),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic push(input logic v, input logic [31:0] s, input logic [31:0] c);
    in_valid  = v;
    in_sine   = s;
    in_cosine = c;
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    count     = '0;
    in_valid  = 1'b0;
    in_sine   = '0;
    in_cosine = '0;
    #12;
    check("rst_csb0", csb0, 1);
    check("rst_web0", web0, 1);
    check("rst_wmask0", wmask0, 0);
    check("rst_addr0", addr0, 0);
    check("rst_din00", din00, 0);
    check("rst_din01", din01, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_rd_inhibit", rd_inhibit, 0);
    check("rst_checksum", checksum, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Basic load: four back-to-back pairs at addresses 0..3
    begin_load(9'd0, 10'd4);
    check("basic_ready", in_ready, 1);
    check("basic_busy", busy, 1);
    check("basic_idle_csb", csb0, 1);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'(2 * i + 1), 32'(2 * i + 2));
      check("basic_csb0", csb0, 0);
      check("basic_web0", web0, 0);
      check("basic_wmask0", wmask0, 4'hF);
      check("basic_addr0", addr0, 32'(i));
      check("basic_din00", din00, 32'(2 * i + 1));
      check("basic_din01", din01, 32'(2 * i + 2));
    end
    check("basic_flush_ready", in_ready, 0);
    push(1'b0, 0, 0);
    check("basic_done", done, 1);
    check("basic_end_csb", csb0, 1);
    check("basic_end_wmask", wmask0, 0);
    check("basic_end_busy", busy, 0);
    check("basic_rdinh_done", rd_inhibit, 1);
    check("basic_checksum", checksum, 32'h1C);
    step();
    check("basic_done_clr", done, 0);
    check("basic_rdinh_clr", rd_inhibit, 0);

    // Wrap with backpressure: writes 510, 511, 0 only in accept cycles
    begin_load(9'd510, 10'd3);
    push(1'b1, 32'hA, 32'hB);
    check("wrap_csb_a", csb0, 0);
    check("wrap_addr_a", addr0, 510);
    push(1'b0, 0, 0);
    check("wrap_gap1_csb", csb0, 1);
    check("wrap_gap1_web", web0, 1);
    check("wrap_gap1_wmask", wmask0, 0);
    push(1'b1, 32'hC, 32'hD);
    check("wrap_csb_b", csb0, 0);
    check("wrap_addr_b", addr0, 511);
    push(1'b0, 0, 0);
    check("wrap_gap2_csb", csb0, 1);
    push(1'b1, 32'hE, 32'hF);
    check("wrap_csb_c", csb0, 0);
    check("wrap_addr_c", addr0, 0);
    check("wrap_din00_c", din00, 32'hE);
    push(1'b0, 0, 0);
    check("wrap_done", done, 1);
    check("wrap_checksum", checksum, 32'h3);
    step();

    // Abort after the 5th accept of a 100-pair load at base 16
    begin_load(9'd16, 10'd100);
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 32'(i), 32'h100);
      check("abort_addr", addr0, 32'(16 + i));
    end
    in_valid = 1'b0;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    check("abort_flush_csb", csb0, 1);
    check("abort_flush_busy", busy, 1);
    check("abort_flush_done", done, 0);
    step();
    check("abort_done", done, 1);
    check("abort_aborted", aborted, 1);
    check("abort_csb", csb0, 1);
    step();
    check("abort_sticky", aborted, 1);

    // count==0: done pulse only, clears aborted, no SRAM access
    begin_load(9'd5, 10'd0);
    check("zero_done", done, 1);
    check("zero_aborted_clr", aborted, 0);
    check("zero_csb", csb0, 1);
    check("zero_busy", busy, 0);
    step();
    check("zero_done_clr", done, 0);
    check("zero_csb2", csb0, 1);

    // Full table: 512 writes from base 0, last lands on 511
    begin_load(9'd0, 10'd512);
    for (int i = 0; i < 512; i++) begin
      push(1'b1, 32'(i), 32'(i));
      if (addr0 !== 9'(i) || csb0 !== 1'b0)
        check("full_addr", {csb0, 22'd0, addr0}, 32'(i));
    end
    check("full_last_addr", addr0, 511);
    check("full_flush_ready", in_ready, 0);
    push(1'b0, 0, 0);
    check("full_done", done, 1);
    check("full_checksum", checksum, 0);
    step();

    // Start with abort in IDLE: start wins; a start mid-load is ignored
    abort = 1'b1;
    begin_load(9'd40, 10'd3);
    abort = 1'b0;
    check("sa_busy", busy, 1);
    check("sa_aborted", aborted, 0);
    push(1'b1, 32'h1, 32'h1);
    check("ign_addr_a", addr0, 40);
    base_addr = 9'd100;
    count     = 10'd5;
    start     = 1'b1;
    push(1'b1, 32'h2, 32'h2);
    start     = 1'b0;
    check("ign_addr_b", addr0, 41);
    push(1'b1, 32'h3, 32'h3);
    check("ign_addr_c", addr0, 42);
    check("ign_flush_rdinh", rd_inhibit, 1);
    check("ign_flush_ready", in_ready, 0);
    push(1'b0, 0, 0);
    check("ign_done", done, 1);
    check("ign_done_rdinh", rd_inhibit, 1);
    step();
    check("ign_idle_busy", busy, 0);
    check("ign_idle_rdinh", rd_inhibit, 0);

    // Asynchronous reset in the middle of a load
    begin_load(9'd0, 10'd10);
    push(1'b1, 32'h5, 32'h6);
    push(1'b1, 32'h7, 32'h8);
    check("mrst_pre_csb", csb0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_csb0", csb0, 1);
    check("mrst_web0", web0, 1);
    check("mrst_busy", busy, 0);
    check("mrst_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("mrst_idle_csb", csb0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
